// File: rtl/chimp_pkg.sv
// Shared definitions for the chimp memory-test control path: board geometry, cell field layout,
// FSM state encoding and the board coordinate helper.
package chimp_pkg;

  localparam int unsigned GRID       = 3;
  localparam int unsigned CELLS      = 9;
  localparam int unsigned CELL_W     = 7;
  localparam int unsigned ACTIVE_BIT = 6;
  localparam int unsigned SHOW_BIT   = 5;
  localparam int unsigned NUM_MSB    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPlace,
    StShow,
    StPlay,
    StResult,
    StOver
  } state_e;

  // Row-major cell index; callers range-check x and y before trusting the result.
  function automatic logic [3:0] cellIndex(input logic [2:0] x, input logic [2:0] y);
    logic [3:0] idx;
    idx = {1'b0, y} * 4'd3 + {1'b0, x};
    return idx;
  endfunction

endpackage

// File: rtl/chimp_place_sel.sv
// Placement target selection: a random nibble is accepted only when it names an empty cell.
module chimp_place_sel
  import chimp_pkg::*;
(
  input  logic [3:0]       iRand,
  input  logic [CELLS-1:0] iActive,
  output logic             oAccept,
  output logic [3:0]       oCell
);

  always_comb begin
    oCell   = iRand;
    oAccept = 1'b0;
    if (iRand < 4'(CELLS)) begin
      oAccept = ~iActive[iRand];
    end
  end

endmodule

// File: rtl/chimp_control_path.sv
// Chimp game control: places numbers 1..oCount on random cells, scores the click order and
// tracks rounds, strikes and game over.
module chimp_control_path
  import chimp_pkg::*;
#(
  parameter int unsigned START_COUNT   = 3,
  parameter int unsigned MAX_STRIKES   = 3,
  parameter int unsigned RESULT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [7:0]  iRandNum,
  input  logic        iClickValid,
  input  logic [2:0]  iBoxX,
  input  logic [2:0]  iBoxY,
  output logic [62:0] oBoard,
  output logic [3:0]  oCount,
  output logic [3:0]  oScore,
  output logic [2:0]  oStrikes,
  output logic        oPass,
  output logic        oGameOver
);

  state_e                       state;
  logic [CELLS-1:0][CELL_W-1:0] board;
  logic [3:0]                   count;
  logic [3:0]                   score;
  logic [2:0]                   strikes;
  logic [3:0]                   placeK;
  logic [3:0]                   expected;
  logic [25:0]                  resCnt;
  logic                         pass;
  logic                         gameOver;

  logic [CELLS-1:0] activeMask;
  logic             placeAccept;
  logic [3:0]       placeCell;
  logic [3:0]       clickIdx;
  logic             clickHit;
  logic [NUM_MSB:0] clickNum;
  logic             unusedRandHi;

  assign unusedRandHi = ^iRandNum[7:4];

  always_comb begin
    for (int i = 0; i < CELLS; i++) begin
      activeMask[i] = board[i][ACTIVE_BIT];
    end
  end

  chimp_place_sel u_place_sel (
    .iRand   (iRandNum[3:0]),
    .iActive (activeMask),
    .oAccept (placeAccept),
    .oCell   (placeCell)
  );

  // A click only counts when it lands on an in-range, active cell.
  always_comb begin
    clickIdx = cellIndex(iBoxX, iBoxY);
    clickHit = 1'b0;
    clickNum = '0;
    if (iClickValid && (iBoxX < 3'(GRID)) && (iBoxY < 3'(GRID))) begin
      clickHit = board[clickIdx][ACTIVE_BIT];
      clickNum = board[clickIdx][NUM_MSB:0];
    end
  end

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state    <= StIdle;
      board    <= '0;
      count    <= 4'(START_COUNT);
      score    <= '0;
      strikes  <= '0;
      placeK   <= 4'd1;
      expected <= 4'd1;
      resCnt   <= '0;
      pass     <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StOver: begin
          if (iStart) begin
            count    <= 4'(START_COUNT);
            score    <= '0;
            strikes  <= '0;
            pass     <= 1'b0;
            gameOver <= 1'b0;
            state    <= StClear;
          end
        end
        StClear: begin
          board  <= '0;
          placeK <= 4'd1;
          state  <= StPlace;
        end
        StPlace: begin
          if (placeAccept) begin
            board[placeCell] <= {2'b11, 1'b0, placeK};
            if (placeK == count) begin
              expected <= 4'd1;
              state    <= StShow;
            end else begin
              placeK <= placeK + 4'd1;
            end
          end
        end
        StShow, StPlay: begin
          if (clickHit) begin
            if (clickNum == {1'b0, expected}) begin
              // The first correct click hides every other number for the rest of the round.
              if (state == StShow) begin
                for (int i = 0; i < CELLS; i++) begin
                  board[i][SHOW_BIT] <= 1'b0;
                end
              end
              board[clickIdx] <= '0;
              if (expected == count) begin
                if (score != 4'hF) score <= score + 4'd1;
                if (count != 4'd9) count <= count + 4'd1;
                pass   <= 1'b1;
                resCnt <= '0;
                state  <= StResult;
              end else begin
                expected <= expected + 4'd1;
                state    <= StPlay;
              end
            end else begin
              for (int i = 0; i < CELLS; i++) begin
                if (board[i][ACTIVE_BIT]) board[i][SHOW_BIT] <= 1'b1;
              end
              strikes <= strikes + 3'd1;
              pass    <= 1'b0;
              resCnt  <= '0;
              state   <= StResult;
            end
          end
        end
        StResult: begin
          if (resCnt == 26'(RESULT_CYCLES - 1)) begin
            pass <= 1'b0;
            if (strikes == 3'(MAX_STRIKES)) begin
              gameOver <= 1'b1;
              state    <= StOver;
            end else begin
              state <= StClear;
            end
          end else begin
            resCnt <= resCnt + 26'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign oBoard    = board;
  assign oCount    = count;
  assign oScore    = score;
  assign oStrikes  = strikes;
  assign oPass     = pass;
  assign oGameOver = gameOver;

endmodule
